// File: rtl/axi_block_mover.sv
// Runtime-programmable AXI4 block copier: bursts from the SRC read port are streamed beat-for-beat to the DST write port.
// Define PERF_COUNT_EN to add the cycle_count output (busy-cycle counter, saturating).
module axi_block_mover #(
  parameter int DW              = 512,
  parameter int AW              = 64,
  parameter int BURST_SIZE      = 4096,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [63:0]   src_address,
  input  logic [63:0]   dst_address,
  input  logic [31:0]   byte_count,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic          error,
`ifdef PERF_COUNT_EN
  output logic [31:0]   cycle_count,
`endif
  output logic [AW-1:0] SRC_AXI_ARADDR,
  output logic [7:0]    SRC_AXI_ARLEN,
  output logic [2:0]    SRC_AXI_ARSIZE,
  output logic [1:0]    SRC_AXI_ARBURST,
  output logic          SRC_AXI_ARVALID,
  input  logic          SRC_AXI_ARREADY,
  output logic [3:0]    SRC_AXI_ARID,
  output logic          SRC_AXI_ARLOCK,
  output logic [3:0]    SRC_AXI_ARCACHE,
  output logic [3:0]    SRC_AXI_ARQOS,
  output logic [2:0]    SRC_AXI_ARPROT,
  input  logic [DW-1:0] SRC_AXI_RDATA,
  input  logic [1:0]    SRC_AXI_RRESP,
  input  logic          SRC_AXI_RLAST,
  input  logic          SRC_AXI_RVALID,
  output logic          SRC_AXI_RREADY,
  output logic          SRC_AXI_AWVALID,
  output logic          SRC_AXI_WVALID,
  output logic          SRC_AXI_BREADY,
  output logic [AW-1:0] DST_AXI_AWADDR,
  output logic [7:0]    DST_AXI_AWLEN,
  output logic [2:0]    DST_AXI_AWSIZE,
  output logic [1:0]    DST_AXI_AWBURST,
  output logic          DST_AXI_AWVALID,
  input  logic          DST_AXI_AWREADY,
  output logic [3:0]    DST_AXI_AWID,
  output logic          DST_AXI_AWLOCK,
  output logic [3:0]    DST_AXI_AWCACHE,
  output logic [3:0]    DST_AXI_AWQOS,
  output logic [2:0]    DST_AXI_AWPROT,
  output logic [DW-1:0] DST_AXI_WDATA,
  output logic [DW/8-1:0] DST_AXI_WSTRB,
  output logic          DST_AXI_WLAST,
  output logic          DST_AXI_WVALID,
  input  logic          DST_AXI_WREADY,
  input  logic [1:0]    DST_AXI_BRESP,
  input  logic          DST_AXI_BVALID,
  output logic          DST_AXI_BREADY,
  output logic          DST_AXI_ARVALID,
  output logic          DST_AXI_RREADY
);
  localparam int BB    = DW / 8;
  localparam int LB    = $clog2(BB);
  localparam int LBS   = $clog2(BURST_SIZE);
  localparam int BEATS = BURST_SIZE / BB;
  localparam logic [7:0]    FULL_LEN = 8'(BEATS - 1);
  localparam logic [AW-1:0] LOW_MASK = AW'(BB - 1);
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_ISSUE = 1'b1;

  logic          ar_state, aw_state;
  logic [31:0]   nbursts, ar_issued, aw_issued, w_bursts, b_count;
  logic [7:0]    last_len, w_beat;
  logic [AW-1:0] ar_addr, aw_addr;

  // Geometry of a new request: whole beats only, last burst carries the remainder.
  logic [31:0] nbytes, start_bursts, rem_beats;
  logic [32:0] nbytes_up;
  logic [7:0]  start_last_len;
  assign nbytes         = byte_count & ~32'(BB - 1);
  assign nbytes_up      = {1'b0, nbytes} + 33'(BURST_SIZE - 1);
  assign start_bursts   = 32'(nbytes_up >> LBS);
  assign rem_beats      = (nbytes & 32'(BURST_SIZE - 1)) >> LB;
  assign start_last_len = (rem_beats == 32'd0) ? FULL_LEN : 8'(rem_beats - 32'd1);

  logic ar_hs, aw_hs, w_hs, b_hs;
  assign ar_hs = SRC_AXI_ARVALID & SRC_AXI_ARREADY;
  assign aw_hs = DST_AXI_AWVALID & DST_AXI_AWREADY;
  assign w_hs  = SRC_AXI_RVALID & DST_AXI_WREADY & busy;
  assign b_hs  = DST_AXI_BVALID & busy;

  assign SRC_AXI_ARADDR  = ar_addr;
  assign SRC_AXI_ARLEN   = (ar_issued == nbursts - 32'd1) ? last_len : FULL_LEN;
  assign SRC_AXI_ARSIZE  = 3'(LB);
  assign SRC_AXI_ARBURST = 2'b01;
  assign SRC_AXI_ARVALID = busy && (ar_state == ST_ISSUE) &&
                           ((ar_issued - w_bursts) < 32'(MAX_OUTSTANDING));
  assign SRC_AXI_ARID    = '0;
  assign SRC_AXI_ARLOCK  = 1'b0;
  assign SRC_AXI_ARCACHE = 4'b0011;
  assign SRC_AXI_ARQOS   = '0;
  assign SRC_AXI_ARPROT  = '0;
  assign SRC_AXI_RREADY  = DST_AXI_WREADY & busy;
  assign SRC_AXI_AWVALID = 1'b0;
  assign SRC_AXI_WVALID  = 1'b0;
  assign SRC_AXI_BREADY  = 1'b0;

  assign DST_AXI_AWADDR  = aw_addr;
  assign DST_AXI_AWLEN   = (aw_issued == nbursts - 32'd1) ? last_len : FULL_LEN;
  assign DST_AXI_AWSIZE  = 3'(LB);
  assign DST_AXI_AWBURST = 2'b01;
  assign DST_AXI_AWVALID = busy && (aw_state == ST_ISSUE);
  assign DST_AXI_AWID    = '0;
  assign DST_AXI_AWLOCK  = 1'b0;
  assign DST_AXI_AWCACHE = 4'b0011;
  assign DST_AXI_AWQOS   = '0;
  assign DST_AXI_AWPROT  = '0;
  assign DST_AXI_WDATA   = SRC_AXI_RDATA;
  assign DST_AXI_WSTRB   = '1;
  assign DST_AXI_WLAST   = (w_beat == ((w_bursts == nbursts - 32'd1) ? last_len : FULL_LEN));
  assign DST_AXI_WVALID  = SRC_AXI_RVALID & busy;
  assign DST_AXI_BREADY  = busy;
  assign DST_AXI_ARVALID = 1'b0;
  assign DST_AXI_RREADY  = 1'b0;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      ar_state  <= ST_IDLE;
      aw_state  <= ST_IDLE;
      nbursts   <= '0;
      last_len  <= '0;
      ar_addr   <= '0;
      aw_addr   <= '0;
      ar_issued <= '0;
      aw_issued <= '0;
      w_bursts  <= '0;
      w_beat    <= '0;
      b_count   <= '0;
    end else begin
      done <= 1'b0;
      if (!busy) begin
        if (start) begin
          error     <= 1'b0;
          nbursts   <= start_bursts;
          last_len  <= start_last_len;
          ar_addr   <= src_address[AW-1:0] & ~LOW_MASK;
          aw_addr   <= dst_address[AW-1:0] & ~LOW_MASK;
          ar_issued <= '0;
          aw_issued <= '0;
          w_bursts  <= '0;
          w_beat    <= '0;
          b_count   <= '0;
          if (start_bursts == 32'd0) begin
            done <= 1'b1;
          end else begin
            busy     <= 1'b1;
            ar_state <= ST_ISSUE;
            aw_state <= ST_ISSUE;
          end
        end
      end else begin
        if (ar_hs) begin
          ar_addr   <= ar_addr + AW'(BURST_SIZE);
          ar_issued <= ar_issued + 32'd1;
          if (ar_issued == nbursts - 32'd1) ar_state <= ST_IDLE;
        end
        if (aw_hs) begin
          aw_addr   <= aw_addr + AW'(BURST_SIZE);
          aw_issued <= aw_issued + 32'd1;
          if (aw_issued == nbursts - 32'd1) aw_state <= ST_IDLE;
        end
        if (w_hs) begin
          if (DST_AXI_WLAST) begin
            w_beat   <= '0;
            w_bursts <= w_bursts + 32'd1;
          end else begin
            w_beat <= w_beat + 8'd1;
          end
          if (SRC_AXI_RRESP != 2'b00 || SRC_AXI_RLAST != DST_AXI_WLAST) error <= 1'b1;
        end
        if (b_hs) begin
          b_count <= b_count + 32'd1;
          if (DST_AXI_BRESP != 2'b00) error <= 1'b1;
        end
        if (b_count == nbursts) begin
          busy     <= 1'b0;
          done     <= 1'b1;
          ar_state <= ST_IDLE;
          aw_state <= ST_IDLE;
        end
      end
    end
  end

`ifdef PERF_COUNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (start && !busy) begin
      cycle_count <= '0;
    end else if (busy && cycle_count != '1) begin
      cycle_count <= cycle_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_axi_block_mover.sv
// Directed bench for axi_block_mover: behavioural SRC read slave and DST write slave with address, length, data and WLAST checking.
module tb_axi_block_mover;
  localparam int DW = 512;
  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic [63:0]   src_address, dst_address;
  logic [31:0]   byte_count;
  logic          start, busy, done, error;
`ifdef PERF_COUNT_EN
  logic [31:0]   cycle_count;
`endif
  logic [AW-1:0] ARADDR, AWADDR;
  logic [7:0]    ARLEN, AWLEN;
  logic [2:0]    ARSIZE, AWSIZE, ARPROT, AWPROT;
  logic [1:0]    ARBURST, AWBURST, RRESP, BRESP;
  logic [3:0]    ARID, AWID, ARCACHE, AWCACHE, ARQOS, AWQOS;
  logic          ARLOCK, AWLOCK;
  logic          ARVALID, ARREADY, RLAST, RVALID, RREADY;
  logic          AWVALID, AWREADY, WLAST, WVALID, WREADY, BVALID, BREADY;
  logic          S_AWVALID, S_WVALID, S_BREADY, D_ARVALID, D_RREADY;
  logic [DW-1:0] RDATA, WDATA;
  logic [DW/8-1:0] WSTRB;

  always #5 clk = ~clk;

  axi_block_mover #(.DW(DW), .AW(AW), .BURST_SIZE(4096), .MAX_OUTSTANDING(2)) dut (
    .clk(clk), .reset(reset),
    .src_address(src_address), .dst_address(dst_address), .byte_count(byte_count),
    .start(start), .busy(busy), .done(done), .error(error),
`ifdef PERF_COUNT_EN
    .cycle_count(cycle_count),
`endif
    .SRC_AXI_ARADDR(ARADDR), .SRC_AXI_ARLEN(ARLEN), .SRC_AXI_ARSIZE(ARSIZE),
    .SRC_AXI_ARBURST(ARBURST), .SRC_AXI_ARVALID(ARVALID), .SRC_AXI_ARREADY(ARREADY),
    .SRC_AXI_ARID(ARID), .SRC_AXI_ARLOCK(ARLOCK), .SRC_AXI_ARCACHE(ARCACHE),
    .SRC_AXI_ARQOS(ARQOS), .SRC_AXI_ARPROT(ARPROT),
    .SRC_AXI_RDATA(RDATA), .SRC_AXI_RRESP(RRESP), .SRC_AXI_RLAST(RLAST),
    .SRC_AXI_RVALID(RVALID), .SRC_AXI_RREADY(RREADY),
    .SRC_AXI_AWVALID(S_AWVALID), .SRC_AXI_WVALID(S_WVALID), .SRC_AXI_BREADY(S_BREADY),
    .DST_AXI_AWADDR(AWADDR), .DST_AXI_AWLEN(AWLEN), .DST_AXI_AWSIZE(AWSIZE),
    .DST_AXI_AWBURST(AWBURST), .DST_AXI_AWVALID(AWVALID), .DST_AXI_AWREADY(AWREADY),
    .DST_AXI_AWID(AWID), .DST_AXI_AWLOCK(AWLOCK), .DST_AXI_AWCACHE(AWCACHE),
    .DST_AXI_AWQOS(AWQOS), .DST_AXI_AWPROT(AWPROT),
    .DST_AXI_WDATA(WDATA), .DST_AXI_WSTRB(WSTRB), .DST_AXI_WLAST(WLAST),
    .DST_AXI_WVALID(WVALID), .DST_AXI_WREADY(WREADY),
    .DST_AXI_BRESP(BRESP), .DST_AXI_BVALID(BVALID), .DST_AXI_BREADY(BREADY),
    .DST_AXI_ARVALID(D_ARVALID), .DST_AXI_RREADY(D_RREADY)
  );

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] pat(input logic [63:0] a);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = (a[31:0] + 32'(i)) ^ a[63:32];
    return d;
  endfunction

  // Knobs set by the stimulus process before each start.
  bit         rnd = 1'b0;
  int         w_stall_init = 0;
  int         err_burst = -1;
  int         exp_nb = 0;
  logic [7:0] exp_last = '0;

  // Model state owned by the slave process.
  logic [63:0] m_src, m_dst;
  int          m_nb;
  logic [7:0]  m_last, last_arlen;
  int ar_cnt, aw_cnt, w_total, w_in, w_burst, b_cnt, done_cnt, valid_cyc;
  int ar_err, aw_err, data_err, wlast_err, max_out, w_stall;

  initial begin
    logic [63:0] arq_a[$];
    logic [7:0]  arq_l[$];
    logic [1:0]  bq[$];
    logic [63:0] r_addr;
    int          r_left;
    bit          r_active, r_hold, b_hold;
    bit          ar_hs, aw_hs, w_hs, b_hs, exp_wl;
    logic [7:0]  el;
    r_active = 0; r_hold = 0; b_hold = 0; r_addr = '0; r_left = 0;
    ARREADY = 0; RVALID = 0; RDATA = '0; RRESP = '0; RLAST = 0;
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        arq_a.delete(); arq_l.delete(); bq.delete();
        r_active = 0; r_hold = 0; b_hold = 0;
        ARREADY = 0; RVALID = 0; RLAST = 0; AWREADY = 0; WREADY = 0; BVALID = 0;
      end else begin
        ARREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        AWREADY = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (!r_hold) begin
          RVALID = 0; RLAST = 0;
          if (!r_active && arq_a.size() > 0) begin
            r_addr = arq_a.pop_front(); r_left = int'(arq_l.pop_front()); r_active = 1;
          end
          if (r_active && (!rnd || $urandom_range(0, 3) != 0)) begin
            RVALID = 1; RDATA = pat(r_addr); RLAST = (r_left == 0); r_hold = 1;
          end
        end
        if (w_stall > 0) begin
          WREADY = 0; w_stall--;
        end else begin
          WREADY = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (!b_hold) begin
          BVALID = 0;
          if (bq.size() > 0 && (!rnd || $urandom_range(0, 1) == 1)) begin
            BVALID = 1; BRESP = bq.pop_front(); b_hold = 1;
          end
        end
        #1;
        if (start && !busy) begin
          m_src = src_address & ~64'h3F; m_dst = dst_address & ~64'h3F;
          m_nb = exp_nb; m_last = exp_last;
          ar_cnt = 0; aw_cnt = 0; w_total = 0; w_in = 0; w_burst = 0; b_cnt = 0;
          done_cnt = 0; valid_cyc = 0; ar_err = 0; aw_err = 0; data_err = 0;
          wlast_err = 0; max_out = 0; w_stall = w_stall_init;
        end
        ar_hs = ARVALID && ARREADY; aw_hs = AWVALID && AWREADY;
        w_hs = WVALID && WREADY;    b_hs = BVALID && BREADY;
        if (ar_hs) begin
          el = (ar_cnt == m_nb - 1) ? m_last : 8'd63;
          if (ARADDR !== m_src + 64'(ar_cnt) * 64'd4096 || ARLEN !== el ||
              ARSIZE !== 3'd6 || ARBURST !== 2'b01) ar_err++;
          arq_a.push_back(ARADDR); arq_l.push_back(ARLEN);
          last_arlen = ARLEN; ar_cnt++;
        end
        if (aw_hs) begin
          el = (aw_cnt == m_nb - 1) ? m_last : 8'd63;
          if (AWADDR !== m_dst + 64'(aw_cnt) * 64'd4096 || AWLEN !== el ||
              AWSIZE !== 3'd6 || AWBURST !== 2'b01) aw_err++;
          aw_cnt++;
        end
        if (RVALID && RREADY) begin
          r_hold = 0; r_addr += 64'd64;
          if (r_left == 0) r_active = 0; else r_left--;
        end
        if (w_hs) begin
          if (WDATA !== pat(m_src + 64'(w_total) * 64'd64) || WSTRB !== '1) data_err++;
          exp_wl = (8'(w_in) == ((w_burst == m_nb - 1) ? m_last : 8'd63));
          if (WLAST !== exp_wl) wlast_err++;
          w_total++;
          if (exp_wl) begin
            bq.push_back((w_burst == err_burst) ? 2'b10 : 2'b00);
            w_burst++; w_in = 0;
          end else begin
            w_in++;
          end
        end
        if (b_hs) begin
          b_hold = 0; b_cnt++;
        end
        if (ar_cnt - w_burst > max_out) max_out = ar_cnt - w_burst;
        if (done) done_cnt++;
        if (ARVALID || AWVALID) valid_cyc++;
      end
    end
  end

  task automatic do_start(input logic [63:0] s, input logic [63:0] d, input logic [31:0] n,
                          input int nb, input logic [7:0] ll);
    @(negedge clk);
    exp_nb = nb; exp_last = ll;
    src_address = s; dst_address = d; byte_count = n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string t, input int budget);
    for (int k = 0; k < budget; k++) begin
      #2;
      if (done) break;
      @(negedge clk);
    end
    check_eq({t, "_done_seen"}, 64'(done), 64'd1);
    repeat (4) @(negedge clk);
    #2;
  endtask

  task automatic check_xfer(input string t, input int nb, input logic exp_err);
    check_eq({t, "_ar_bursts"}, 64'(ar_cnt), 64'(nb));
    check_eq({t, "_aw_bursts"}, 64'(aw_cnt), 64'(nb));
    check_eq({t, "_b_count"}, 64'(b_cnt), 64'(nb));
    check_eq({t, "_ar_fields"}, 64'(ar_err), 64'd0);
    check_eq({t, "_aw_fields"}, 64'(aw_err), 64'd0);
    check_eq({t, "_wdata"}, 64'(data_err), 64'd0);
    check_eq({t, "_wlast"}, 64'(wlast_err), 64'd0);
    check_eq({t, "_done_once"}, 64'(done_cnt), 64'd1);
    check_eq({t, "_outstanding_le2"}, 64'(max_out <= 2), 64'd1);
    check_eq({t, "_error"}, 64'(error), 64'(exp_err));
    check_eq({t, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    src_address = '0; dst_address = '0; byte_count = '0;
    repeat (3) @(negedge clk);
    #2;
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_error", 64'(error), 64'd0);
    check_eq("rst_arvalid", 64'(ARVALID), 64'd0);
    check_eq("rst_awvalid", 64'(AWVALID), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // 1 MiB: 256 full bursts of 64 beats
    do_start(64'h0, 64'h1_0000_0000, 32'h0010_0000, 256, 8'd63);
    wait_done("mib", 40000);
    check_xfer("mib", 256, 1'b0);
    check_eq("mib_last_arlen", 64'(last_arlen), 64'd63);

    // 4096+192 bytes: LEN 63 then LEN 2
    do_start(64'h2000, 64'h8000, 32'd4288, 2, 8'd2);
    wait_done("tail", 2000);
    check_xfer("tail", 2, 1'b0);
    check_eq("tail_last_arlen", 64'(last_arlen), 64'd2);

    // 300 bytes from unaligned addresses: rounds down to 4 beats at 0x3000/0x9000
    do_start(64'h3013, 64'h9021, 32'd300, 1, 8'd3);
    wait_done("unal", 2000);
    check_xfer("unal", 1, 1'b0);

    // 63 bytes rounds to zero: no traffic, done one cycle after start
    do_start(64'h4000, 64'h5000, 32'd63, 0, 8'd0);
    #2;
    check_eq("zero_done", 64'(done), 64'd1);
    check_eq("zero_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    #2;
    check_eq("zero_done_once", 64'(done_cnt), 64'd1);
    check_eq("zero_no_valid", 64'(valid_cyc), 64'd0);
    check_eq("zero_done_low", 64'(done), 64'd0);

    // WREADY stalled 1000 cycles plus random stalls; a start while busy must be ignored
    rnd = 1'b1; w_stall_init = 1000;
    do_start(64'h1_0000, 64'h2_0000, 32'd32768, 8, 8'd63);
    repeat (20) @(negedge clk);
    src_address = 64'hDEAD_0000; byte_count = 32'd64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("stall", 30000);
    check_xfer("stall", 8, 1'b0);
    check_eq("stall_outstanding_max", 64'(max_out), 64'd2);
    w_stall_init = 0; rnd = 1'b0;

    // SLVERR on burst 5 of 8, then a clean transfer clears the sticky error
    err_burst = 5;
    do_start(64'h4_0000, 64'h5_0000, 32'd32768, 8, 8'd63);
    wait_done("slverr", 5000);
    check_xfer("slverr", 8, 1'b1);
    err_burst = -1;
    do_start(64'h6_0000, 64'h7_0000, 32'd128, 1, 8'd1);
    #2;
    check_eq("clr_error_at_start", 64'(error), 64'd0);
    check_eq("clr_busy_at_start", 64'(busy), 64'd1);
    wait_done("clr", 2000);
    check_xfer("clr", 1, 1'b0);

    // Reset mid-transfer, then a fresh transfer with random stalls
    rnd = 1'b1;
    do_start(64'h8_0000, 64'h9_0000, 32'd16384, 4, 8'd63);
    repeat (60) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    check_eq("midrst_busy", 64'(busy), 64'd0);
    check_eq("midrst_arvalid", 64'(ARVALID), 64'd0);
    check_eq("midrst_done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    do_start(64'hA_0000, 64'hB_0000, 32'd4288, 2, 8'd2);
    wait_done("after_rst", 5000);
    check_xfer("after_rst", 2, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
